one_to_sixteen_deser: RTL

ONE_TO_SIXTEEN_DESER -- requirements
Module: one_to_sixteen_deser

---
 rtl/one_to_sixteen_deser.sv | 119 +++++++++++
 1 files changed

// File: rtl/one_to_sixteen_deser.sv
// ---------------------------------------------------------------------------
// one_to_sixteen_deser
//
// Collects a serial bit stream into 16-bit parallel words. Bits are accepted
// with a valid/ready handshake and gathered in an assembly register. On the
// 16th bit the finished word moves into a registered output holding stage.
// That stage is consumed with its own valid/ready handshake. One word of
// overlap is allowed: bits 0..14 of the next word may arrive while the
// previous word is still waiting. Only the 16th bit stalls.
//
// Parameters
//   LSB_FIRST  1: first accepted bit lands in out_data[0]
//              0: first accepted bit lands in out_data[15]
//
// Ports
//   clk        rising-edge clock for all state
//   rst        asynchronous, active-high reset
//   in_bit     serial data bit
//   in_valid   in_bit is valid this cycle
//   in_ready   block can accept in_bit this cycle (combinational)
//   in_flush   synchronous discard of the partial word
//   out_data   assembled parallel word (registered)
//   out_valid  out_data holds an unconsumed word (registered)
//   out_ready  consumer takes out_data this cycle
//   fill_cnt   number of bits in the partial word (0..15)
// ---------------------------------------------------------------------------
module one_to_sixteen_deser #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_bit,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_flush,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  fill_cnt
);

  logic [3:0]  fill_q, fill_d;
  logic [15:0] asm_q, asm_d;
  logic [15:0] data_q, data_d;
  logic        valid_q, valid_d;

  logic        in_xfer;
  logic        out_xfer;
  logic        last_bit;
  logic [3:0]  wr_idx;
  logic [15:0] asm_wr;

  // The 16th bit may only enter when the holding stage is empty or is
  // being drained on this same edge.
  assign last_bit = (fill_q == 4'd15);
  assign in_ready = !(last_bit && valid_q && !out_ready);
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = valid_q && out_ready;

  assign wr_idx = LSB_FIRST ? fill_q : (4'd15 - fill_q);

  // The assembly word with the incoming bit merged in at its slot. It is
  // used for the normal update and for the word loaded on the 16th bit.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_wr
      assign asm_wr[gi] = (wr_idx == 4'(gi)) ? in_bit : asm_q[gi];
    end
  endgenerate

  always_comb begin
    fill_d  = fill_q;
    asm_d   = asm_q;
    data_d  = data_q;
    valid_d = valid_q;

    if (out_xfer) begin
      valid_d = 1'b0;
    end

    // Flush wins over a same-edge input transfer. It never touches the
    // holding stage, so a same-edge output transfer still completes.
    if (in_flush) begin
      fill_d = 4'd0;
      asm_d  = 16'h0000;
    end else if (in_xfer) begin
      if (last_bit) begin
        // Word complete. A new load overrides a same-edge drain, so
        // out_valid stays high without a bubble.
        data_d  = asm_wr;
        valid_d = 1'b1;
        fill_d  = 4'd0;
        asm_d   = 16'h0000;
      end else begin
        fill_d = fill_q + 4'd1;
        asm_d  = asm_wr;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_q  <= 4'd0;
      asm_q   <= 16'h0000;
      data_q  <= 16'h0000;
      valid_q <= 1'b0;
    end else begin
      fill_q  <= fill_d;
      asm_q   <= asm_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign fill_cnt  = fill_q;

endmodule
